imem_loader: RTL and testbench

Boot-time writer for the 1024-byte, big-endian instruction memory that the datapath fetches from. It accepts a byte stream over a valid/ready handshake and writes each byte in stream order to consecutive instruction-memory addresses starting at 0. It then checks an XOR checksum trailer and holds the CPU (via `PC` reset) for the whole load. It sits between an external host link and the instruction memory's byte write port.

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory byte write port of the boot loader.
// The host side drives the stream; the loader consumes it and drives the memory.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        BYTE_IN;
  logic              BYTE_VALID;
  logic              BYTE_READY;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_WDATA;

  // Host / memory side: supplies bytes, observes the write port.
  modport master (
    output BYTE_IN, BYTE_VALID,
    input  BYTE_READY, MEM_WE, MEM_ADDR, MEM_WDATA
  );

  // Loader side: consumes bytes, drives the write port.
  modport slave (
    input  BYTE_IN, BYTE_VALID,
    output BYTE_READY, MEM_WE, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: streams 4*LEN_WORDS bytes into
// addresses 0.. in order, then checks an XOR checksum trailer byte.
// The CPU is held at PC 0 for the whole load and after any failure.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-2:0] LEN_WORDS,
  imem_loader_if.slave      bus,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              ERROR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  // Memory capacity in bytes, one bit wider than an address.
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic [ADDR_W-2:0] len_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [7:0]        sum_q;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;

  logic              fire;
  logic              len_ok;
  logic              last_byte;
  logic [ADDR_W:0]   req_bytes;
  logic [ADDR_W:0]   last_idx;

  // Handshake and length decode; ready is registered so no path from BYTE_VALID.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    fire      = 1'b0;
    req_bytes = '0;
    len_ok    = 1'b0;
    last_idx  = '0;
    last_byte = 1'b0;
    fire      = bus.BYTE_VALID & ready_q;
    req_bytes = {LEN_WORDS, 2'b00};
    len_ok    = (LEN_WORDS != '0) && (req_bytes <= CAP);
    last_idx  = {len_q, 2'b00} - {{ADDR_W{1'b0}}, 1'b1};
    last_byte = (ptr_q == last_idx[ADDR_W-1:0]);
  end

  // Loader FSM with all outputs registered.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      ptr_q   <= '0;
      sum_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (START) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (len_ok) begin
              state_q <= S_LOAD;
              len_q   <= LEN_WORDS;
              ptr_q   <= '0;
              sum_q   <= '0;
              ready_q <= 1'b1;
              hold_q  <= 1'b1;
            end else begin
              state_q <= S_ERR;
              ready_q <= 1'b0;
              hold_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (fire) begin
            we_q    <= 1'b1;
            addr_q  <= ptr_q;
            wdata_q <= bus.BYTE_IN;
            sum_q   <= sum_q ^ bus.BYTE_IN;
            // Pointer stops at the last index so it never exceeds the memory.
            if (last_byte) begin
              state_q <= S_CHECK;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (fire) begin
            ready_q <= 1'b0;
            if (bus.BYTE_IN == sum_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BYTE_READY = ready_q;
  assign bus.MEM_WE     = we_q;
  assign bus.MEM_ADDR   = addr_q;
  assign bus.MEM_WDATA  = wdata_q;
  assign CPU_HOLD       = hold_q;
  assign DONE           = done_q;
  assign ERROR          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: accepted data bytes push their expected
// write into a scoreboard; a monitor pops and compares every MEM_WE strobe.
module tb_imem_loader;
  localparam int ADDR_W = 10;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              START;
  logic [ADDR_W-2:0] LEN_WORDS;
  logic              CPU_HOLD, DONE, ERROR;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .LEN_WORDS (LEN_WORDS),
    .bus       (bus.slave),
    .CPU_HOLD  (CPU_HOLD),
    .DONE      (DONE),
    .ERROR     (ERROR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int n_writes = 0;
  logic [ADDR_W+7:0] sb_q[$];
  logic [ADDR_W-1:0] exp_addr;
  logic [7:0]        exp_sum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding accepted byte.
  always @(negedge CLK) begin
    if (bus.MEM_WE === 1'b1) begin
      n_writes++;
      if (sb_q.size() == 0) begin
        check("we_unexpected", {31'd0, bus.MEM_WE}, 32'd0);
      end else begin
        logic [ADDR_W+7:0] e;
        e = sb_q.pop_front();
        check("wr_addr", 32'(bus.MEM_ADDR), 32'(e[ADDR_W+7:8]));
        check("wr_data", 32'(bus.MEM_WDATA), 32'(e[7:0]));
      end
    end
  end

  // Pulse START for one cycle; returns #1 after the accepting edge.
  task automatic start_load(input int len);
    START     = 1'b1;
    LEN_WORDS = (ADDR_W-1)'(len);
    @(posedge CLK); #1;
    START = 1'b0;
    exp_addr = '0;
    exp_sum  = '0;
  endtask

  // Offer one byte until accepted (bounded); data bytes go to the scoreboard.
  task automatic send_byte(input logic [7:0] b, input bit is_data);
    bit taken = 1'b0;
    bus.BYTE_IN    = b;
    bus.BYTE_VALID = 1'b1;
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge CLK);
      if (bus.BYTE_READY === 1'b1) begin
        taken = 1'b1;
        if (is_data) begin
          sb_q.push_back({exp_addr, b});
          exp_addr = exp_addr + 1'b1;
          exp_sum  = exp_sum ^ b;
        end
        @(posedge CLK); #1;
      end
    end
    bus.BYTE_VALID = 1'b0;
    if (!taken) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycle(input bit pulse_start);
    START     = pulse_start;
    LEN_WORDS = '0;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic check_status(input string tag, input bit rdy, input bit hold,
                              input bit done, input bit err);
    check({tag, "_ready"}, {31'd0, bus.BYTE_READY}, {31'd0, rdy});
    check({tag, "_hold"},  {31'd0, CPU_HOLD},       {31'd0, hold});
    check({tag, "_done"},  {31'd0, DONE},           {31'd0, done});
    check({tag, "_error"}, {31'd0, ERROR},          {31'd0, err});
  endtask

  initial begin
    int w0;
    RESET = 1'b1; START = 1'b0; LEN_WORDS = '0;
    bus.BYTE_IN = '0; bus.BYTE_VALID = 1'b0;
    exp_addr = '0; exp_sum = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // Reset state
    check_status("reset", 0, 0, 0, 0);
    check("reset_we",    {31'd0, bus.MEM_WE}, 32'd0);
    check("reset_addr",  32'(bus.MEM_ADDR),   32'd0);
    check("reset_wdata", 32'(bus.MEM_WDATA),  32'd0);

    // Single word, correct checksum 31
    start_load(1);
    check_status("sw_start", 1, 1, 0, 0);
    w0 = n_writes;
    send_byte(8'h00, 1); send_byte(8'h01, 1); send_byte(8'h10, 1); send_byte(8'h20, 1);
    check("sw_in_check_ready", {31'd0, bus.BYTE_READY}, 32'd1);
    send_byte(8'h31, 0);
    check_status("sw_end", 0, 0, 1, 0);
    check("sw_writes", n_writes - w0, 4);

    // Restart from DONE; two words with gaps and START pulses during LOAD
    start_load(2);
    check_status("gap_start", 1, 1, 0, 0);
    w0 = n_writes;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(8'hA5 + 8'(i * 17)), 1);
      idle_cycle(i == 2 || i == 5);
    end
    check_status("gap_in_check", 1, 1, 0, 0);
    send_byte(exp_sum, 0);
    check_status("gap_end", 0, 0, 1, 0);
    check("gap_writes", n_writes - w0, 8);

    // Bad checksum: 30 instead of 31
    start_load(1);
    w0 = n_writes;
    send_byte(8'h00, 1); send_byte(8'h01, 1); send_byte(8'h10, 1); send_byte(8'h20, 1);
    send_byte(8'h30, 0);
    check_status("badsum", 0, 1, 0, 1);
    check("badsum_writes", n_writes - w0, 4);

    // Invalid lengths from ERR; a byte is offered but must not be consumed
    w0 = n_writes;
    bus.BYTE_IN = 8'h55; bus.BYTE_VALID = 1'b1;
    start_load(0);
    check_status("len0", 0, 1, 0, 1);
    idle_cycle(0);
    start_load(257);
    check_status("len257", 0, 1, 0, 1);
    idle_cycle(0); idle_cycle(0);
    check("badlen_ready", {31'd0, bus.BYTE_READY}, 32'd0);
    check("badlen_writes", n_writes - w0, 0);
    bus.BYTE_VALID = 1'b0;

    // Maximum load: 256 words fill addresses 0..1023
    start_load(256);
    check_status("max_start", 1, 1, 0, 0);
    w0 = n_writes;
    for (int i = 0; i < 1024; i++) send_byte(8'(i * 7 + 3), 1);
    send_byte(exp_sum, 0);
    check_status("max_end", 0, 0, 1, 0);
    check("max_writes", n_writes - w0, 1024);

    // Reset mid-load after two accepted bytes
    start_load(1);
    send_byte(8'hDE, 1); send_byte(8'hAD, 1);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check_status("midrst", 0, 0, 0, 0);
    check("midrst_we",   {31'd0, bus.MEM_WE}, 32'd0);
    check("midrst_addr", 32'(bus.MEM_ADDR),   32'd0);
    check("midrst_sb",   sb_q.size(),         0);
    start_load(1);
    w0 = n_writes;
    send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'h56, 1); send_byte(8'h78, 1);
    send_byte(8'h08, 0);
    check_status("post_rst", 0, 0, 1, 0);
    check("post_rst_writes", n_writes - w0, 4);

    idle_cycle(0); idle_cycle(0);
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
